// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-bank completer.
// Optional error responses are enabled with APB_SLAVE_PSLVERR_EN.
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int APB_ADDR_W    = 32;
    localparam int APB_DATA_W    = 32;
    localparam int STATUS_WR_LSB = 16;
    localparam int STATUS_RD_LSB = 0;

    function automatic int idx_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/apb_slave_wait_cnt.sv
// Loadable down-counter; done marks the cycle a completer may raise pready.
// Shared by the APB completer models.
module apb_slave_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register bank and wait states.
// Define APB_SLAVE_PSLVERR_EN to return pslverr on bad accesses.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IW   = idx_w(NUM_REGS);
    localparam int STAT = NUM_REGS - 1;
    localparam logic [APB_ADDR_W-1:0] SPAN = APB_ADDR_W'(NUM_REGS * 4);

    state_t state;
    state_t state_nx;

    logic [APB_ADDR_W-1:0] addr_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic                  write_q;

    logic [APB_DATA_W-1:0] regs [NUM_REGS-1];
    logic [15:0]           wr_cnt;
    logic [15:0]           rd_cnt;

    logic                  setup;
    logic                  done;
    logic                  commit;
    logic [APB_ADDR_W-1:0] offset;
    logic [IW-1:0]         idx;
    logic                  invalid;
    logic                  ro_wr;
    logic [APB_DATA_W-1:0] rdata;

    assign setup   = (state == IDLE) && psel && !penable;
    assign offset  = addr_q - BASE_ADDR;
    assign idx     = offset[IW+1:2];
    assign invalid = (addr_q < BASE_ADDR) || (offset >= SPAN)
                   || (addr_q[1:0] != 2'b00);
    assign ro_wr   = write_q && (idx == IW'(STAT));

    // pready comes only from registered state, never from APB inputs
    assign pready = (state == ACCESS) && done;
    assign commit = pready && psel && penable;

    apb_slave_wait_cnt #(
        .W(4)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (setup),
        .value(4'(WAIT_CYCLES)),
        .done (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || commit) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (setup) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            write_q <= pwrite;
        end
    end

    // Only committed accesses to valid addresses touch state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (commit && !invalid) begin
            if (write_q) begin
                if (!ro_wr) begin
                    regs[idx] <= wdata_q;
                    wr_cnt    <= wr_cnt + 16'd1;
                end
            end else begin
                rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (!invalid) begin
            if (idx == IW'(STAT)) begin
                rdata[STATUS_WR_LSB +: 16] = wr_cnt;
                rdata[STATUS_RD_LSB +: 16] = rd_cnt;
            end else begin
                rdata = regs[idx];
            end
        end
    end

    assign prdata = pready ? rdata : '0;

`ifdef APB_SLAVE_PSLVERR_EN
    assign pslverr = pready && (invalid || ro_wr);
`else
    assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: two completers (no wait / 3 waits, offset base)
// driven by directed and random transfers against a register-bank model.
module tb_apb_slave_regfile;

    localparam logic [31:0] B1 = 32'h0000_1000;
`ifdef APB_SLAVE_PSLVERR_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        psel     [2];
    logic        penable  [2];
    logic        pwrite   [2];
    logic [31:0] paddr    [2];
    logic [31:0] pwdata   [2];
    logic [31:0] prdata_a [2];
    logic        pready_a [2];
    logic        pslverr_a[2];

    int ncomp = 0;
    int nfail = 0;

    logic [31:0] mreg[2][16];
    logic [15:0] mw[2];
    logic [15:0] mr[2];

    always #5 clk = ~clk;

    apb_slave_regfile #(
        .NUM_REGS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)
    ) u_w0 (
        .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata_a[0]), .pready(pready_a[0]),
        .pslverr(pslverr_a[0])
    );

    apb_slave_regfile #(
        .NUM_REGS(16), .WAIT_CYCLES(3), .BASE_ADDR(B1)
    ) u_w3 (
        .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata_a[1]), .pready(pready_a[1]),
        .pslverr(pslverr_a[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mreg[k][i] = '0;
            mw[k] = '0;
            mr[k] = '0;
        end
    endtask

    // Register-bank semantics: 15 RW words plus a read-only status word
    task automatic model(input int k, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] exp_rd,
                         output logic exp_err);
        logic [31:0] base;
        logic [31:0] off;
        bit          ok;
        int          i;
        base = (k == 0) ? 32'h0 : B1;
        off  = a - base;
        ok   = (a >= base) && (off < 32'd64) && (a[1:0] == 2'b00);
        i    = int'(off / 4);
        exp_rd  = '0;
        exp_err = 1'b0;
        if (!ok) begin
            exp_err = EE;
        end else if (wr) begin
            if (i == 15) begin
                exp_err = EE;
            end else begin
                mreg[k][i] = d;
                mw[k]++;
            end
        end else begin
            exp_rd = (i == 15) ? {mw[k], mr[k]} : mreg[k][i];
            mr[k]++;
        end
    endtask

    // Entered just after a rising edge; returns just after the commit edge
    task automatic xfer(input int k, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input string tag,
                        output logic [31:0] rd, output logic err,
                        output int waits);
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = a;
        pwdata[k]  = d;
        @(posedge clk);
        #1 penable[k] = 1'b1;
        waits = 0;
        @(negedge clk);
        while (pready_a[k] !== 1'b1 && waits < 40) begin
            chk({tag, "_prdata_wait"}, prdata_a[k], 32'h0);
            waits++;
            @(negedge clk);
        end
        rd  = prdata_a[k];
        err = pslverr_a[k];
        @(posedge clk);
        #1;
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
    endtask

    task automatic run(input int k, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] rd;
        logic        err;
        int          waits;
        model(k, wr, a, d, exp_rd, exp_err);
        xfer(k, wr, a, d, tag, rd, err, waits);
        chk({tag, "_lat"}, 32'(waits), (k == 0) ? 32'd0 : 32'd3);
        chk({tag, "_prdata"}, wr ? exp_rd : rd, exp_rd);
        chk({tag, "_pslverr"}, {31'h0, err}, {31'h0, exp_err});
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        int          r;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psel[i]    = 1'b0;
            penable[i] = 1'b0;
            pwrite[i]  = 1'b0;
            paddr[i]   = '0;
            pwdata[i]  = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_pready%0d", i), {31'h0, pready_a[i]}, 32'h0);
            chk($sformatf("rst_prdata%0d", i), prdata_a[i], 32'h0);
            chk($sformatf("rst_pslverr%0d", i), {31'h0, pslverr_a[i]}, 32'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(0, 1'b1, 32'h04, 32'h0000_0008, "w0_wr04");
        run(0, 1'b0, 32'h04, 32'h0, "w0_rd04");
        run(1, 1'b0, B1 + 32'h00, 32'h0, "w3_rd00");
        run(0, 1'b1, 32'h08, 32'h0000_0055, "w0_wr08");
        run(0, 1'b0, 32'h3C, 32'h0, "w0_status");

        run(0, 1'b0, 32'h06, 32'h0, "rd_misaligned");
        run(0, 1'b1, 32'h40, 32'hFFFF_FFFF, "wr_out_of_window");
        run(0, 1'b1, 32'h3C, 32'h1234_5678, "wr_status");
        run(1, 1'b0, 32'h0, 32'h0, "rd_below_base");
        run(0, 1'b0, 32'h3C, 32'h0, "w0_status_after_err");

        // Abort: drop psel in the second access cycle of a waited write
        psel[1]    = 1'b1;
        penable[1] = 1'b0;
        pwrite[1]  = 1'b1;
        paddr[1]   = B1 + 32'h08;
        pwdata[1]  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 penable[1] = 1'b1;
        @(negedge clk);
        chk("abort_acc1_pready", {31'h0, pready_a[1]}, 32'h0);
        @(posedge clk);
        #1;
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        @(posedge clk);
        #1;
        run(1, 1'b0, B1 + 32'h08, 32'h0, "abort_rd08");
        run(1, 1'b0, B1 + 32'h3C, 32'h0, "abort_status");

        for (int n = 0; n < 80; n++) begin
            k = n % 2;
            r = int'($urandom_range(0, 9));
            a = (k == 0) ? 32'h0 : B1;
            if (r < 7) a = a + 32'(4 * $urandom_range(0, 15));
            else if (r == 7) a = a + 32'(4 * $urandom_range(0, 15))
                               + 32'($urandom_range(1, 3));
            else if (r == 8) a = a + 32'd64 + 32'(4 * $urandom_range(0, 7));
            else a = a - 32'd4;
            run(k, 1'($urandom_range(0, 1)), a, $urandom(),
                $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a waited write
        psel[1]    = 1'b1;
        penable[1] = 1'b0;
        pwrite[1]  = 1'b1;
        paddr[1]   = B1 + 32'h0C;
        pwdata[1]  = 32'h1234_5678;
        @(posedge clk);
        #1 penable[1] = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_pready", {31'h0, pready_a[1]}, 32'h0);
        chk("midrst_prdata", prdata_a[1], 32'h0);
        @(posedge clk);
        #1;
        run(1, 1'b0, B1 + 32'h3C, 32'h0, "midrst_status");
        for (int i = 0; i < 15; i++) begin
            run(1, 1'b0, B1 + 32'(4 * i), 32'h0, $sformatf("midrst_r%0d", i));
        end
        run(0, 1'b0, 32'h3C, 32'h0, "midrst_w0_status");
        run(0, 1'b0, 32'h04, 32'h0, "midrst_w0_r1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end

endmodule
